// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between requester channels, the arbiter, and the internal-RAM and SDRAM backends.
// The slave view belongs to the arbiter. The master view belongs to whatever drives requests and models the backends.
interface mem_port_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 25
);
  logic [NCH-1:0]    req_enable;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*2-1:0]  req_oplen;
  logic [NCH-1:0]    req_unsigned;
  logic [NCH-1:0]    req_rw;
  logic [NCH*32-1:0] req_wdata;
  logic [NCH-1:0]    resp_valid;
  logic [NCH-1:0]    resp_err;
  logic [NCH*32-1:0] resp_rdata;

  logic              im_enable;
  logic [AW-1:0]     im_addr;
  logic              im_rw;
  logic [3:0]        im_wstrb;
  logic [31:0]       im_wdata;
  logic              im_valid;
  logic [31:0]       im_rdata;

  logic              sm_enable;
  logic [AW-1:0]     sm_addr;
  logic              sm_rw;
  logic [3:0]        sm_wstrb;
  logic [31:0]       sm_wdata;
  logic              sm_valid;
  logic [31:0]       sm_rdata;

  modport slave (
    input  req_enable, req_addr, req_oplen, req_unsigned, req_rw, req_wdata,
    output resp_valid, resp_err, resp_rdata,
    output im_enable, im_addr, im_rw, im_wstrb, im_wdata,
    input  im_valid, im_rdata,
    output sm_enable, sm_addr, sm_rw, sm_wstrb, sm_wdata,
    input  sm_valid, sm_rdata
  );

  modport master (
    output req_enable, req_addr, req_oplen, req_unsigned, req_rw, req_wdata,
    input  resp_valid, resp_err, resp_rdata,
    input  im_enable, im_addr, im_rw, im_wstrb, im_wdata,
    output im_valid, im_rdata,
    input  sm_enable, sm_addr, sm_rw, sm_wstrb, sm_wdata,
    output sm_valid, sm_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Multi-channel memory front-end. Round-robin arbitration onto internal RAM (target 0) and SDRAM (target 1).
// Also handles byte-lane alignment of stores, extension of loads, misalignment detection and backend timeout.
module mem_port_arbiter #(
  parameter int NCH        = 2,
  parameter int AW         = 25,
  parameter int IRAM_BYTES = 16384,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int          CW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int          TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0] IRAM_LIMIT = (AW+1)'(IRAM_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] p, input int k);
    return CW'((int'(p) + k) % NCH);
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] ofs, input logic [1:0] len);
    logic [3:0] m;
    m = 4'((5'd2 << len) - 5'd1);
    return m << ofs;
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [1:0] ofs);
    return wd << {ofs, 3'b000};
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] ofs,
                                           input logic [1:0] len, input logic uns);
    logic [31:0] sh;
    logic        s;
    sh = word >> {ofs, 3'b000};
    unique case (len)
      2'd0: begin s = sh[7]  & ~uns; return {{24{s}}, sh[7:0]};  end
      2'd1: begin s = sh[15] & ~uns; return {{16{s}}, sh[15:0]}; end
      2'd2: begin s = sh[23] & ~uns; return {{8{s}},  sh[23:0]}; end
      default: return sh;
    endcase
  endfunction

  logic [AW-1:0]  ch_addr  [NCH];
  logic [1:0]     ch_oplen [NCH];
  logic [31:0]    ch_wdata [NCH];
  logic [NCH-1:0] ch_sdram, ch_mis, ch_busy;
  logic [NCH-1:0] elig [2];

  state_e         state_q [2], state_d [2];
  logic [CW-1:0]  owner_q [2], owner_d [2];
  logic [CW-1:0]  ptr_q   [2], ptr_d   [2];
  logic [CW-1:0]  gnt_ch  [2];
  logic           gnt_vld [2];
  logic [TW-1:0]  cnt_q   [2], cnt_d   [2];
  logic           err_q   [2], err_d   [2];
  logic [NCH-1:0] mis_q, mis_d;

  logic [AW-1:0]  addr_q  [2];
  logic [1:0]     oplen_q [2];
  logic           uns_q   [2], rw_q [2];
  logic [31:0]    wdata_q [2], rdata_q [2];

  logic           m_valid [2], m_en [2], m_rw [2];
  logic [31:0]    m_rdata [2], m_wd [2];
  logic [AW-1:0]  m_addr  [2];
  logic [3:0]     m_strb  [2];
  logic [NCH-1:0]    resp_valid, resp_err;
  logic [NCH*32-1:0] resp_rdata;

  assign m_valid[0] = bus.im_valid;
  assign m_valid[1] = bus.sm_valid;
  assign m_rdata[0] = bus.im_rdata;
  assign m_rdata[1] = bus.sm_rdata;

  // A channel stays ineligible while any target owns it, including its response cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i]  = bus.req_addr[i*AW +: AW];
      ch_oplen[i] = bus.req_oplen[i*2 +: 2];
      ch_wdata[i] = bus.req_wdata[i*32 +: 32];
      ch_sdram[i] = !({1'b0, ch_addr[i]} < IRAM_LIMIT);
      ch_mis[i]   = ({1'b0, ch_addr[i][1:0]} + {1'b0, ch_oplen[i]}) > 3'd3;
      ch_busy[i]  = mis_q[i];
      for (int t = 0; t < 2; t++) begin
        if (state_q[t] != IDLE && owner_q[t] == CW'(i)) ch_busy[i] = 1'b1;
      end
      for (int t = 0; t < 2; t++) begin
        elig[t][i] = bus.req_enable[i] & ~ch_mis[i] & ~ch_busy[i] & (ch_sdram[i] == (t != 0));
      end
    end
    mis_d = bus.req_enable & ch_mis & ~ch_busy;
  end

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      gnt_vld[t] = 1'b0;
      gnt_ch[t]  = '0;
      for (int k = 0; k < NCH; k++) begin
        if (!gnt_vld[t] && elig[t][rr_idx(ptr_q[t], k)]) begin
          gnt_vld[t] = 1'b1;
          gnt_ch[t]  = rr_idx(ptr_q[t], k);
        end
      end

      state_d[t] = state_q[t];
      owner_d[t] = owner_q[t];
      ptr_d[t]   = ptr_q[t];
      cnt_d[t]   = cnt_q[t];
      err_d[t]   = err_q[t];
      unique case (state_q[t])
        IDLE: begin
          if (gnt_vld[t]) begin
            state_d[t] = ISSUE;
            owner_d[t] = gnt_ch[t];
            ptr_d[t]   = rr_idx(gnt_ch[t], 1);
            cnt_d[t]   = '0;
          end
        end
        ISSUE: begin
          if (m_valid[t]) begin
            state_d[t] = RESP;
            err_d[t]   = 1'b0;
          end else if (TIMEOUT != 0 && cnt_q[t] == TW'(TIMEOUT - 1)) begin
            state_d[t] = RESP;
            err_d[t]   = 1'b1;
          end else begin
            cnt_d[t] = cnt_q[t] + 1'b1;
          end
        end
        default: state_d[t] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < 2; t++) begin
        state_q[t] <= IDLE;
        owner_q[t] <= '0;
        ptr_q[t]   <= '0;
        cnt_q[t]   <= '0;
        err_q[t]   <= 1'b0;
      end
      mis_q <= '0;
    end else begin
      for (int t = 0; t < 2; t++) begin
        state_q[t] <= state_d[t];
        owner_q[t] <= owner_d[t];
        ptr_q[t]   <= ptr_d[t];
        cnt_q[t]   <= cnt_d[t];
        err_q[t]   <= err_d[t];
      end
      mis_q <= mis_d;
    end
  end

  // Request fields are captured at grant. Load data is captured while issuing; it is zero on writes and timeouts.
  always_ff @(posedge clk) begin
    for (int t = 0; t < 2; t++) begin
      if (state_q[t] == IDLE && gnt_vld[t]) begin
        addr_q[t]  <= ch_addr[gnt_ch[t]];
        oplen_q[t] <= ch_oplen[gnt_ch[t]];
        uns_q[t]   <= bus.req_unsigned[gnt_ch[t]];
        rw_q[t]    <= bus.req_rw[gnt_ch[t]];
        wdata_q[t] <= ch_wdata[gnt_ch[t]];
      end
      if (state_q[t] == ISSUE) begin
        rdata_q[t] <= (m_valid[t] && !rw_q[t]) ?
                      load_ext(m_rdata[t], addr_q[t][1:0], oplen_q[t], uns_q[t]) : '0;
      end
    end
  end

  always_comb begin
    resp_valid = mis_q;
    resp_err   = mis_q;
    resp_rdata = '0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NCH; i++) begin
        if (state_q[t] == RESP && owner_q[t] == CW'(i)) begin
          resp_valid[i]         = 1'b1;
          resp_err[i]           = err_q[t];
          resp_rdata[i*32 +: 32] = rdata_q[t];
        end
      end
      m_en[t]   = (state_q[t] == ISSUE);
      m_addr[t] = m_en[t] ? {addr_q[t][AW-1:2], 2'b00} : '0;
      m_rw[t]   = m_en[t] & rw_q[t];
      m_strb[t] = m_rw[t] ? store_strb(addr_q[t][1:0], oplen_q[t]) : 4'b0000;
      m_wd[t]   = m_rw[t] ? store_data(wdata_q[t], addr_q[t][1:0]) : 32'h0;
    end
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_err;
  assign bus.resp_rdata = resp_rdata;

  assign bus.im_enable = m_en[0];
  assign bus.im_addr   = m_addr[0];
  assign bus.im_rw     = m_rw[0];
  assign bus.im_wstrb  = m_strb[0];
  assign bus.im_wdata  = m_wd[0];

  assign bus.sm_enable = m_en[1];
  assign bus.sm_addr   = m_addr[1];
  assign bus.sm_rw     = m_rw[1];
  assign bus.sm_wstrb  = m_strb[1];
  assign bus.sm_wdata  = m_wd[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two channels, TIMEOUT=16, backends modelled by hand-driven valid pulses.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NCH(2), .AW(25)) bus ();

  mem_port_arbiter #(.NCH(2), .AW(25), .IRAM_BYTES(16384), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic [24:0] a, input logic [1:0] len,
                         input logic uns, input logic rw, input logic [31:0] wd);
    bus.req_addr[ch*25 +: 25]  = a;
    bus.req_oplen[ch*2 +: 2]   = len;
    bus.req_unsigned[ch]       = uns;
    bus.req_rw[ch]             = rw;
    bus.req_wdata[ch*32 +: 32] = wd;
    bus.req_enable[ch]         = 1'b1;
  endtask

  task automatic clr_req(input int ch);
    bus.req_enable[ch] = 1'b0;
  endtask

  initial begin
    int   ng;
    int   n;
    logic seen;
    logic gnt [4];

    rst              = 1'b1;
    bus.req_enable   = '0;
    bus.req_addr     = '0;
    bus.req_oplen    = '0;
    bus.req_unsigned = '0;
    bus.req_rw       = '0;
    bus.req_wdata    = '0;
    bus.im_valid     = 1'b1;
    bus.im_rdata     = 32'hDEADBEEF;
    bus.sm_valid     = 1'b1;
    bus.sm_rdata     = 32'hDEADBEEF;
    repeat (3) tick();
    rst          = 1'b0;
    bus.im_valid = 1'b0;
    bus.sm_valid = 1'b0;
    chk("rst_resp_valid", bus.resp_valid, 2'b00);
    chk("rst_resp_err",   bus.resp_err,   2'b00);
    chk("rst_resp_rdata", bus.resp_rdata, 64'h0);
    chk("rst_im_enable",  bus.im_enable,  1'b0);
    chk("rst_sm_enable",  bus.sm_enable,  1'b0);

    // ch0 word read from internal RAM; backend answers on the third enabled cycle
    set_req(0, 25'h000010, 2'b11, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rd_im_enable", bus.im_enable, 1'b1);
    chk("rd_im_addr",   bus.im_addr,   25'h000010);
    chk("rd_im_rw",     bus.im_rw,     1'b0);
    chk("rd_no_early",  bus.resp_valid, 2'b00);
    tick();
    tick();
    bus.im_valid = 1'b1;
    bus.im_rdata = 32'h8899AABB;
    tick();
    bus.im_valid = 1'b0;
    clr_req(0);
    chk("rd_resp_valid", bus.resp_valid, 2'b01);
    chk("rd_rdata",      bus.resp_rdata[31:0], 32'h8899AABB);
    chk("rd_err",        bus.resp_err, 2'b00);
    chk("rd_im_dropped", bus.im_enable, 1'b0);
    tick();
    chk("rd_pulse_once", bus.resp_valid, 2'b00);

    // ch1 signed and unsigned byte loads at offset 3; valid on first enabled cycle
    set_req(1, 25'h000013, 2'b00, 1'b0, 1'b0, 32'h0);
    tick();
    chk("lb_im_addr", bus.im_addr, 25'h000010);
    bus.im_valid = 1'b1;
    bus.im_rdata = 32'h80112233;
    tick();
    bus.im_valid = 1'b0;
    clr_req(1);
    chk("lb_resp_valid", bus.resp_valid, 2'b10);
    chk("lb_signed",     bus.resp_rdata[63:32], 32'hFFFFFF80);
    tick();
    set_req(1, 25'h000013, 2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    bus.im_valid = 1'b1;
    tick();
    bus.im_valid = 1'b0;
    clr_req(1);
    chk("lbu_unsigned", bus.resp_rdata[63:32], 32'h00000080);
    tick();

    // ch1 halfword store to SDRAM at byte offset 2
    set_req(1, 25'h1000002, 2'b01, 1'b0, 1'b1, 32'h00001234);
    tick();
    chk("st_sm_enable", bus.sm_enable, 1'b1);
    chk("st_im_idle",   bus.im_enable, 1'b0);
    chk("st_sm_addr",   bus.sm_addr,   25'h1000000);
    chk("st_sm_rw",     bus.sm_rw,     1'b1);
    chk("st_sm_wstrb",  bus.sm_wstrb,  4'b1100);
    chk("st_sm_wdata",  bus.sm_wdata,  32'h12340000);
    bus.sm_valid = 1'b1;
    bus.sm_rdata = 32'hFFFFFFFF;
    tick();
    bus.sm_valid = 1'b0;
    clr_req(1);
    chk("st_resp_valid", bus.resp_valid, 2'b10);
    chk("st_rdata_zero", bus.resp_rdata[63:32], 32'h0);
    tick();

    // both channels hammer internal RAM: grants must alternate starting at ch0
    set_req(0, 25'h000020, 2'b11, 1'b0, 1'b0, 32'h0);
    set_req(1, 25'h000024, 2'b11, 1'b0, 1'b0, 32'h0);
    ng = 0;
    for (int c = 0; c < 24 && ng < 4; c++) begin
      tick();
      if (bus.im_enable) begin
        gnt[ng]      = (bus.im_addr == 25'h000024);
        ng++;
        bus.im_valid = 1'b1;
        bus.im_rdata = 32'hA5A5A5A5;
      end else begin
        bus.im_valid = 1'b0;
      end
    end
    chk("alt_grant_count", 64'(ng), 64'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < ng) chk($sformatf("alt_grant%0d", j), 64'(gnt[j]), 64'(j % 2));
    end
    tick();
    bus.im_valid = 1'b0;
    clr_req(0);
    clr_req(1);
    tick();
    tick();

    // concurrent: ch0 internal RAM, ch1 SDRAM
    set_req(0, 25'h000030, 2'b11, 1'b0, 1'b0, 32'h0);
    set_req(1, 25'h1000100, 2'b11, 1'b0, 1'b0, 32'h0);
    tick();
    chk("par_im_enable", bus.im_enable, 1'b1);
    chk("par_sm_enable", bus.sm_enable, 1'b1);
    bus.im_valid = 1'b1;
    bus.im_rdata = 32'h11111111;
    bus.sm_valid = 1'b1;
    bus.sm_rdata = 32'h22222222;
    tick();
    bus.im_valid = 1'b0;
    bus.sm_valid = 1'b0;
    clr_req(0);
    clr_req(1);
    chk("par_resp_valid", bus.resp_valid, 2'b11);
    chk("par_rdata",      bus.resp_rdata, 64'h22222222_11111111);
    tick();

    // misaligned word read: immediate error, no backend activity
    set_req(1, 25'h000005, 2'b11, 1'b0, 1'b0, 32'h0);
    tick();
    clr_req(1);
    chk("mis_resp_valid", bus.resp_valid, 2'b10);
    chk("mis_resp_err",   bus.resp_err,   2'b10);
    chk("mis_rdata",      bus.resp_rdata[63:32], 32'h0);
    chk("mis_im_enable",  bus.im_enable, 1'b0);
    chk("mis_sm_enable",  bus.sm_enable, 1'b0);
    tick();
    chk("mis_im_after",   bus.im_enable, 1'b0);
    chk("mis_pulse_once", bus.resp_valid, 2'b00);

    // silent internal RAM: error after 16 enabled cycles, stray valid afterwards ignored
    set_req(0, 25'h000040, 2'b11, 1'b0, 1'b0, 32'h0);
    tick();
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus.resp_valid[0]) begin
        seen = 1'b1;
      end else begin
        if (bus.im_enable) n++;
        tick();
      end
    end
    chk("to_resp_seen",     64'(seen), 64'd1);
    chk("to_enabled_count", 64'(n),    64'd16);
    chk("to_resp_err",      bus.resp_err, 2'b01);
    chk("to_im_dropped",    bus.im_enable, 1'b0);
    clr_req(0);
    tick();
    bus.im_valid = 1'b1;
    tick();
    bus.im_valid = 1'b0;
    chk("to_stray_ignored", bus.resp_valid, 2'b00);
    tick();
    chk("to_stray_quiet",   bus.resp_valid, 2'b00);

    // reset while SDRAM transaction is outstanding; late valid dropped
    set_req(1, 25'h1000200, 2'b11, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rstm_sm_enable", bus.sm_enable, 1'b1);
    tick();
    rst = 1'b1;
    clr_req(1);
    tick();
    chk("rstm_sm_low", bus.sm_enable, 1'b0);
    rst          = 1'b0;
    bus.sm_valid = 1'b1;
    tick();
    bus.sm_valid = 1'b0;
    chk("rstm_no_resp", bus.resp_valid, 2'b00);
    tick();
    chk("rstm_quiet",   bus.resp_valid, 2'b00);
    chk("rstm_sm_idle", bus.sm_enable,  1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
